// File: rtl/rv32i_pkg.sv
// RV32I decode constants, the decoded bundle layout and the ALU op selector.
package rv32i_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_SLL  = 8'h03;
  localparam logic [7:0] ALU_SLT  = 8'h04;
  localparam logic [7:0] ALU_SLTU = 8'h05;
  localparam logic [7:0] ALU_XOR  = 8'h06;
  localparam logic [7:0] ALU_SRL  = 8'h07;
  localparam logic [7:0] ALU_SRA  = 8'h08;
  localparam logic [7:0] ALU_OR   = 8'h09;
  localparam logic [7:0] ALU_AND  = 8'h0a;

  typedef struct packed {
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic [7:0]  op;
    logic        re1;
    logic        re2;
    logic        we;
    logic        pce;
    logic        imme;
    logic        jmpe;
    logic        bre;
    logic        mre;
    logic        mwe;
    logic [2:0]  funct3;
    logic        illegal;
  } dec_t;

  localparam int unsigned DEC_W = $bits(dec_t);

  // alt selects sub (funct3=0) or sra (funct3=5)
  function automatic logic [7:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [7:0] r;
    case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction word to decoded bundle.
module decode_comb
  import rv32i_pkg::*;
(
  input  logic [31:0] prog,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        bad;

  assign opc   = prog[6:0];
  assign rd    = prog[11:7];
  assign f3    = prog[14:12];
  assign rs1   = prog[19:15];
  assign rs2   = prog[24:20];
  assign f7    = prog[31:25];
  assign imm_i = {{20{prog[31]}}, prog[31:20]};
  assign imm_s = {{20{prog[31]}}, prog[31:25], prog[11:7]};
  assign imm_b = {{19{prog[31]}}, prog[31], prog[7], prog[30:25], prog[11:8], 1'b0};
  assign imm_u = {prog[31:12], 12'h000};
  assign imm_j = {{11{prog[31]}}, prog[31], prog[19:12], prog[20], prog[30:21], 1'b0};

  // Field/enable mapping per opcode, then illegal squash and x0 write suppression.
  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.funct3 = f3;
    case (opc)
      OPC_R: begin
        dec.ra1 = rs1; dec.ra2 = rs2; dec.wa = rd;
        dec.re1 = 1'b1; dec.re2 = 1'b1; dec.we = 1'b1;
        dec.op  = alu_from_f3(f3, f7[5]);
        if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        else if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) bad = 1'b1;
      end
      OPC_I: begin
        dec.ra1 = rs1; dec.wa = rd; dec.imm = imm_i;
        dec.re1 = 1'b1; dec.we = 1'b1; dec.imme = 1'b1;
        dec.op  = alu_from_f3(f3, (f3 == 3'd5) & f7[5]);
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
      end
      OPC_LOAD: begin
        dec.ra1 = rs1; dec.wa = rd; dec.imm = imm_i;
        dec.re1 = 1'b1; dec.we = 1'b1; dec.imme = 1'b1; dec.mre = 1'b1;
        dec.op  = ALU_ADD;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
      end
      OPC_STORE: begin
        dec.ra1 = rs1; dec.ra2 = rs2; dec.imm = imm_s;
        dec.re1 = 1'b1; dec.re2 = 1'b1; dec.imme = 1'b1; dec.mwe = 1'b1;
        dec.op  = ALU_ADD;
        if (f3 > 3'd2) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec.ra1 = rs1; dec.ra2 = rs2; dec.imm = imm_b;
        dec.re1 = 1'b1; dec.re2 = 1'b1; dec.bre = 1'b1;
        dec.op  = ALU_SUB;
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
      end
      OPC_JAL: begin
        dec.wa  = rd; dec.imm = imm_j;
        dec.we  = 1'b1; dec.pce = 1'b1; dec.imme = 1'b1; dec.jmpe = 1'b1;
        dec.op  = ALU_ADD;
      end
      OPC_JALR: begin
        dec.ra1 = rs1; dec.wa = rd; dec.imm = imm_i;
        dec.re1 = 1'b1; dec.we = 1'b1; dec.imme = 1'b1; dec.jmpe = 1'b1;
        dec.op  = ALU_ADD;
        if (f3 != 3'd0) bad = 1'b1;
      end
      OPC_LUI: begin
        dec.wa = rd; dec.imm = imm_u;
        dec.we = 1'b1; dec.imme = 1'b1;
        dec.op = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.wa = rd; dec.imm = imm_u;
        dec.we = 1'b1; dec.pce = 1'b1; dec.imme = 1'b1;
        dec.op = ALU_ADD;
      end
      OPC_FENCE: begin
        dec.op = ALU_NOP;
      end
      default: bad = 1'b1;  // includes OPC_SYSTEM: trapped downstream
    endcase
    if (bad) begin
      dec         = '0;
      dec.funct3  = f3;
      dec.illegal = 1'b1;
    end
    if (dec.wa == 5'd0) dec.we = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides and optional skid entry.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned PC_W = 32,
  parameter int unsigned OP_W = 8,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_prog,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_ra1,
  output logic [4:0]      out_ra2,
  output logic [4:0]      out_wa,
  output logic [31:0]     out_imm,
  output logic [OP_W-1:0] out_op,
  output logic            out_re1,
  output logic            out_re2,
  output logic            out_we,
  output logic            out_pce,
  output logic            out_imme,
  output logic            out_jmpe,
  output logic            out_bre,
  output logic            out_mre,
  output logic            out_mwe,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  dec_t             in_dec;
  dec_t             out_d;
  logic             main_v;
  logic [DEC_W-1:0] main_q;
  logic [PC_W-1:0]  main_pc;
  logic             acc;
  logic             drain;

  decode_comb u_decode_comb (
    .prog (in_prog),
    .dec  (in_dec)
  );

  assign acc   = in_valid & in_ready;
  assign drain = main_v & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_v;
      logic [DEC_W-1:0] skid_q;
      logic [PC_W-1:0]  skid_pc;

      assign in_ready = ~skid_v;

      // Main/skid pair: skid only fills while main is held, and refills main on drain.
      always_ff @(posedge clk) begin
        if (rst) begin
          main_v  <= 1'b0;
          main_q  <= '0;
          main_pc <= '0;
          skid_v  <= 1'b0;
          skid_q  <= '0;
          skid_pc <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (skid_v) begin
          if (drain) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
            skid_v  <= 1'b0;
          end
        end else if (acc) begin
          if (main_v && !drain) begin
            skid_q  <= in_dec;
            skid_pc <= in_pc;
            skid_v  <= 1'b1;
          end else begin
            main_q  <= in_dec;
            main_pc <= in_pc;
            main_v  <= 1'b1;
          end
        end else if (drain) begin
          main_v <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready = out_ready | ~main_v;

      // Single output register, refilled in the same edge it drains.
      always_ff @(posedge clk) begin
        if (rst) begin
          main_v  <= 1'b0;
          main_q  <= '0;
          main_pc <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
        end else if (acc) begin
          main_q  <= in_dec;
          main_pc <= in_pc;
          main_v  <= 1'b1;
        end else if (drain) begin
          main_v <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_d       = dec_t'(main_q);
  assign out_valid   = main_v;
  assign out_pc      = main_pc;
  assign out_ra1     = out_d.ra1;
  assign out_ra2     = out_d.ra2;
  assign out_wa      = out_d.wa;
  assign out_imm     = out_d.imm;
  assign out_op      = OP_W'(out_d.op);
  assign out_re1     = out_d.re1;
  assign out_re2     = out_d.re2;
  assign out_we      = out_d.we;
  assign out_pce     = out_d.pce;
  assign out_imme    = out_d.imme;
  assign out_jmpe    = out_d.jmpe;
  assign out_bre     = out_d.bre;
  assign out_mre     = out_d.mre;
  assign out_mwe     = out_d.mwe;
  assign out_funct3  = out_d.funct3;
  assign out_illegal = out_d.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage (SKID=1) plus stall/flush/reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_prog;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_ra1, out_ra2, out_wa;
  logic [31:0] out_imm;
  logic [7:0]  out_op;
  logic        out_re1, out_re2, out_we, out_pce, out_imme, out_jmpe, out_bre, out_mre, out_mwe;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .OP_W(8), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_prog(in_prog), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ra1(out_ra1), .out_ra2(out_ra2), .out_wa(out_wa), .out_imm(out_imm), .out_op(out_op),
    .out_re1(out_re1), .out_re2(out_re2), .out_we(out_we), .out_pce(out_pce),
    .out_imme(out_imme), .out_jmpe(out_jmpe), .out_bre(out_bre), .out_mre(out_mre),
    .out_mwe(out_mwe), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // en = {re1,re2,we,pce,imme,jmpe,bre,mre,mwe}
  typedef struct {
    logic [31:0] prog;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic [7:0]  op;
    logic [8:0]  en;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  logic [8:0] en_act;
  assign en_act = {out_re1, out_re2, out_we, out_pce, out_imme, out_jmpe, out_bre, out_mre, out_mwe};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] pc);
    in_valid = 1'b1;
    in_prog  = p;
    in_pc    = pc;
    @(posedge clk); #1;
  endtask

  initial begin
    tv[0]  = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h00000000, 8'h01, 9'b111000000, 3'd0, 1'b0}; // add x3,x1,x2
    tv[1]  = '{32'hFFC12283, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC, 8'h01, 9'b101010010, 3'd2, 1'b0}; // lw x5,-4(x2)
    tv[2]  = '{32'h00612423, 5'd2, 5'd6, 5'd0, 32'h00000008, 8'h01, 9'b110010001, 3'd2, 1'b0}; // sw x6,8(x2)
    tv[3]  = '{32'hFE208CE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 8'h02, 9'b110000100, 3'd0, 1'b0}; // beq -8
    tv[4]  = '{32'h00000000, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd0, 1'b1}; // zero word
    tv[5]  = '{32'h00000013, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h01, 9'b100010000, 3'd0, 1'b0}; // addi x0
    tv[6]  = '{32'h00000073, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd0, 1'b1}; // ecall
    tv[7]  = '{32'h407302B3, 5'd6, 5'd7, 5'd5, 32'h00000000, 8'h02, 9'b111000000, 3'd0, 1'b0}; // sub
    tv[8]  = '{32'h407312B3, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd1, 1'b1}; // f7=0x20 sll
    tv[9]  = '{32'h40315093, 5'd2, 5'd0, 5'd1, 32'h00000403, 8'h08, 9'b101010000, 3'd5, 1'b0}; // srai
    tv[10] = '{32'h40311093, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd1, 1'b1}; // bad slli
    tv[11] = '{32'h004100E7, 5'd2, 5'd0, 5'd1, 32'h00000004, 8'h01, 9'b101011000, 3'd0, 1'b0}; // jalr
    tv[12] = '{32'h004110E7, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd1, 1'b1}; // jalr f3=1
    tv[13] = '{32'hFFDFF0EF, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFC, 8'h01, 9'b001111000, 3'd7, 1'b0}; // jal -4
    tv[14] = '{32'h123453B7, 5'd0, 5'd0, 5'd7, 32'h12345000, 8'h01, 9'b001010000, 3'd5, 1'b0}; // lui
    tv[15] = '{32'h80000117, 5'd0, 5'd0, 5'd2, 32'h80000000, 8'h01, 9'b001110000, 3'd0, 1'b0}; // auipc
    tv[16] = '{32'h0FF0000F, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd0, 1'b0}; // fence
    tv[17] = '{32'h00003003, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd3, 1'b1}; // load f3=3
    tv[18] = '{32'h00002063, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd2, 1'b1}; // branch f3=2
    tv[19] = '{32'h00003023, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 9'b000000000, 3'd3, 1'b1}; // store f3=3
    tv[20] = '{32'h003170B3, 5'd2, 5'd3, 5'd1, 32'h00000000, 8'h0A, 9'b111000000, 3'd7, 1'b0}; // and
    tv[21] = '{32'h00208033, 5'd1, 5'd2, 5'd0, 32'h00000000, 8'h01, 9'b110000000, 3'd0, 1'b0}; // add x0

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_prog = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    // input offered during reset must not be taken
    @(negedge clk); in_valid = 1'b1; in_prog = 32'h002081B3; in_pc = 32'h44;
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_fields", {out_imm, out_op, en_act, out_funct3, out_illegal},
        64'd0);
    chk("rst_addr", 64'({out_ra1, out_ra2, out_wa}), 64'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_no_accept", 64'(out_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      push(tv[i].prog, 32'h1000 + 32'(4 * i));
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
      chk($sformatf("v%0d_addr", i), 64'({out_ra1, out_ra2, out_wa}),
          64'({tv[i].ra1, tv[i].ra2, tv[i].wa}));
      chk($sformatf("v%0d_imm", i), 64'(out_imm), 64'(tv[i].imm));
      chk($sformatf("v%0d_op", i), 64'(out_op), 64'(tv[i].op));
      chk($sformatf("v%0d_en", i), 64'(en_act), 64'(tv[i].en));
      chk($sformatf("v%0d_f3_ill", i), 64'({out_funct3, out_illegal}), 64'({tv[i].f3, tv[i].ill}));
    end
    @(posedge clk); #1;
    chk("drained", 64'(out_valid), 64'd0);

    // stall with two entries, then release: A, B, C in order
    out_ready = 1'b0;
    push(32'h002081B3, 32'hA0);
    chk("stall_a_valid", 64'(out_valid), 64'd1);
    chk("stall_a_in_ready", 64'(in_ready), 64'd1);
    push(32'hFFC12283, 32'hB0);
    chk("stall_b_in_ready", 64'(in_ready), 64'd0);
    chk("stall_hold_pc1", 64'(out_pc), 64'hA0);
    push(32'h00612423, 32'hC0);
    chk("stall_c_held_ready", 64'(in_ready), 64'd0);
    chk("stall_hold_pc2", 64'(out_pc), 64'hA0);
    chk("stall_hold_op", 64'(out_op), 64'h01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_b_pc", 64'(out_pc), 64'hB0);
    chk("rel_b_mre", 64'(out_mre), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rel_c_valid", 64'(out_valid), 64'd1);
    chk("rel_c_pc", 64'(out_pc), 64'hC0);
    chk("rel_c_imm", 64'(out_imm), 64'd8);
    @(posedge clk); #1;
    chk("rel_empty", 64'(out_valid), 64'd0);
    chk("rel_empty_ready", 64'(in_ready), 64'd1);

    // flush while stalled with two entries, and with a same-cycle accept
    out_ready = 1'b0;
    push(32'h002081B3, 32'hA4);
    push(32'hFFC12283, 32'hB4);
    flush = 1'b1;
    push(32'h00612423, 32'hC4);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    push(32'h003170B3, 32'hD4);
    chk("flush_accept_dropped", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_no_stale%0d", k), 64'(out_valid), 64'd0);
    end
    push(32'h123453B7, 32'hE0);
    in_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_pc", 64'(out_pc), 64'hE0);
    chk("post_flush_imm", 64'(out_imm), 64'h12345000);
    @(posedge clk); #1;

    // reset mid-stall
    out_ready = 1'b0;
    push(32'h002081B3, 32'hA8);
    push(32'hFFC12283, 32'hB8);
    rst = 1'b1;
    push(32'h00612423, 32'hC8);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_pc", 64'(out_pc), 64'd0);
    chk("mrst_fields", {out_imm, out_op, en_act, out_funct3, out_illegal}, 64'd0);
    chk("mrst_addr", 64'({out_ra1, out_ra2, out_wa}), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst_no_stale%0d", k), 64'(out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
